// File: rtl/acude_level_tracker.sv
// Water-level tracker: synchronises and debounces a 2-bit level switch code,
// walks the reported level one step per clock toward it, and latches an overflow alarm.
//
// state | meaning
// L0    | level 00, empty
// L1    | level 01, low
// L2    | level 10, high
// L3    | level 11, full (sets the alarm)
module acude_level_tracker #(
  parameter int DEBOUNCE = 3,
  parameter int BLINK    = 2
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic [1:0] sensor,
  input  logic       alarm_ack,
  output logic [1:0] level,
  output logic       changed,
  output logic       busy,
  output logic       full,
  output logic       alarm,
  output logic       alarm_blink
);

  typedef enum logic [1:0] {L0 = 2'b00, L1 = 2'b01, L2 = 2'b10, L3 = 2'b11} level_t;

  localparam logic [3:0] DB_MAX = 4'(DEBOUNCE - 1);
  localparam logic [3:0] BL_MAX = 4'(BLINK - 1);

  level_t     state, state_nxt;
  logic [1:0] sync1, s, cand, tgt;
  logic [3:0] cnt, bcnt;
  logic       blink_q;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      sync1 <= 2'b00;
      s     <= 2'b00;
      cand  <= 2'b00;
      cnt   <= 4'd0;
      tgt   <= 2'b00;
    end else begin
      sync1 <= sensor;
      s     <= sync1;
      if (s != cand) begin
        cand <= s;
        cnt  <= 4'd0;
      end else begin
        if (cnt < DB_MAX) cnt <= cnt + 4'd1;
        // Stable for DEBOUNCE+1 samples once the counter is already saturated
        if (cnt == DB_MAX) tgt <= cand;
      end
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state   <= L0;
      changed <= 1'b0;
    end else begin
      state   <= state_nxt;
      changed <= (state_nxt != state);
    end
  end

  always_comb begin
    state_nxt = state;
    if (state < tgt)      state_nxt = level_t'(2'(state + 2'd1));
    else if (state > tgt) state_nxt = level_t'(2'(state - 2'd1));
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      alarm   <= 1'b0;
      bcnt    <= 4'd0;
      blink_q <= 1'b0;
    end else begin
      if (state == L3)    alarm <= 1'b1;
      else if (alarm_ack) alarm <= 1'b0;

      if (!alarm) begin
        bcnt    <= 4'd0;
        blink_q <= 1'b0;
      end else if (bcnt == BL_MAX) begin
        bcnt    <= 4'd0;
        blink_q <= ~blink_q;
      end else begin
        bcnt <= bcnt + 4'd1;
      end
    end
  end

  assign level       = state;
  assign busy        = (state != tgt);
  assign full        = (state == L3);
  // Gated so the blink output drops in the same cycle the alarm clears
  assign alarm_blink = blink_q & alarm;

endmodule

// File: tb/tb_acude_level_tracker.sv
// Directed bench for acude_level_tracker: vector table plus hand sequences
// for glitch rejection, mid-travel reversal and asynchronous reset.
module tb_acude_level_tracker;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic [1:0] sensor, sensor_f;
  logic       alarm_ack, alarm_ack_f;
  logic [1:0] level, level_f;
  logic       changed, busy, full, alarm, alarm_blink;
  logic       changed_f, busy_f, full_f, alarm_f, alarm_blink_f;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_2 = ~clk_2;

  acude_level_tracker #(.DEBOUNCE(3), .BLINK(2)) dut (
    .clk_2(clk_2), .reset(reset), .sensor(sensor), .alarm_ack(alarm_ack),
    .level(level), .changed(changed), .busy(busy), .full(full),
    .alarm(alarm), .alarm_blink(alarm_blink)
  );

  // Shortest debounce: the only setting where a target can change mid-travel
  acude_level_tracker #(.DEBOUNCE(1), .BLINK(1)) dut_fast (
    .clk_2(clk_2), .reset(reset), .sensor(sensor_f), .alarm_ack(alarm_ack_f),
    .level(level_f), .changed(changed_f), .busy(busy_f), .full(full_f),
    .alarm(alarm_f), .alarm_blink(alarm_blink_f)
  );

  typedef struct {
    logic       rst;
    logic [1:0] sen;
    logic       ack;
    int         hold;
    logic [1:0] lv;
    logic       ch, bz, fu, al, bl;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string tag, input logic [1:0] lv,
                     input logic ch, bz, fu, al, bl);
    n_vec++;
    if ({level, changed, busy, full, alarm, alarm_blink} !== {lv, ch, bz, fu, al, bl}) begin
      n_bad++;
      $display("FAIL %s: got lv=%b ch=%b bz=%b fu=%b al=%b bl=%b, expected lv=%b ch=%b bz=%b fu=%b al=%b bl=%b",
               tag, level, changed, busy, full, alarm, alarm_blink, lv, ch, bz, fu, al, bl);
    end
  endtask

  task automatic chk_fast(input string tag, input logic [1:0] lv, input logic ch, al);
    n_vec++;
    if ({level_f, changed_f, alarm_f} !== {lv, ch, al}) begin
      n_bad++;
      $display("FAIL %s: got lv=%b ch=%b al=%b, expected lv=%b ch=%b al=%b",
               tag, level_f, changed_f, alarm_f, lv, ch, al);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk_2);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    edges(1);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] f_lv[9];
    logic       f_ch[9];

    //           rst   sen    ack  hold lv     ch bz fu al bl
    tbl.push_back('{1'b0, 2'b00, 1'b0, 5, 2'b00, 0, 0, 0, 0, 0});
    tbl.push_back('{1'b0, 2'b01, 1'b0, 5, 2'b00, 0, 0, 0, 0, 0});
    tbl.push_back('{1'b0, 2'b01, 1'b0, 1, 2'b00, 0, 1, 0, 0, 0});
    tbl.push_back('{1'b0, 2'b01, 1'b0, 1, 2'b01, 1, 0, 0, 0, 0});
    tbl.push_back('{1'b0, 2'b01, 1'b0, 1, 2'b01, 0, 0, 0, 0, 0});
    tbl.push_back('{1'b1, 2'b01, 1'b0, 1, 2'b00, 0, 0, 0, 0, 0});
    tbl.push_back('{1'b0, 2'b11, 1'b0, 6, 2'b00, 0, 1, 0, 0, 0});
    tbl.push_back('{1'b0, 2'b11, 1'b0, 1, 2'b01, 1, 1, 0, 0, 0});
    tbl.push_back('{1'b0, 2'b11, 1'b0, 1, 2'b10, 1, 1, 0, 0, 0});
    tbl.push_back('{1'b0, 2'b11, 1'b0, 1, 2'b11, 1, 0, 1, 0, 0});
    tbl.push_back('{1'b0, 2'b11, 1'b0, 1, 2'b11, 0, 0, 1, 1, 0});
    tbl.push_back('{1'b0, 2'b11, 1'b0, 1, 2'b11, 0, 0, 1, 1, 0});
    tbl.push_back('{1'b0, 2'b11, 1'b0, 1, 2'b11, 0, 0, 1, 1, 1});
    tbl.push_back('{1'b0, 2'b11, 1'b0, 1, 2'b11, 0, 0, 1, 1, 1});
    tbl.push_back('{1'b0, 2'b11, 1'b0, 1, 2'b11, 0, 0, 1, 1, 0});
    tbl.push_back('{1'b0, 2'b11, 1'b1, 1, 2'b11, 0, 0, 1, 1, 0});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 6, 2'b11, 0, 1, 1, 1, 1});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 1, 2'b10, 1, 0, 0, 1, 0});
    tbl.push_back('{1'b0, 2'b10, 1'b1, 1, 2'b10, 0, 0, 0, 0, 0});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 2, 2'b10, 0, 0, 0, 0, 0});

    f_lv = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
    f_ch = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    reset = 1'b1; sensor = 2'b00; alarm_ack = 1'b0;
    sensor_f = 2'b00; alarm_ack_f = 1'b0;
    edges(2);
    chk("reset_state", 2'b00, 0, 0, 0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; sensor = tbl[i].sen; alarm_ack = tbl[i].ack;
      edges(tbl[i].hold);
      chk($sformatf("vec%0d", i), tbl[i].lv, tbl[i].ch, tbl[i].bz,
          tbl[i].fu, tbl[i].al, tbl[i].bl);
    end
    alarm_ack = 1'b0;

    // Glitch of DEBOUNCE cycles must never reach the target
    pulse_reset();
    sensor = 2'b00;
    edges(5);
    sensor = 2'b10;
    for (int i = 0; i < 3; i++) begin
      edges(1);
      chk($sformatf("glitch_hi%0d", i), 2'b00, 0, 0, 0, 0, 0);
    end
    sensor = 2'b00;
    for (int i = 0; i < 12; i++) begin
      edges(1);
      chk($sformatf("glitch_lo%0d", i), 2'b00, 0, 0, 0, 0, 0);
    end
    // One cycle longer is accepted
    sensor = 2'b10;
    edges(4);
    sensor = 2'b00;
    edges(1);
    chk("accept_edge5", 2'b00, 0, 0, 0, 0, 0);
    edges(1);
    chk("accept_edge6", 2'b00, 0, 1, 0, 0, 0);

    // Async reset mid-travel, then restart from 00
    pulse_reset();
    sensor = 2'b10;
    edges(7);
    chk("travel_e7", 2'b01, 1, 1, 0, 0, 0);
    edges(1);
    chk("travel_e8", 2'b10, 1, 0, 0, 0, 0);
    #1 reset = 1'b1;
    #1 chk("async_reset", 2'b00, 0, 0, 0, 0, 0);
    sensor = 2'b01;
    #1 reset = 1'b0;
    edges(6);
    chk("restart_e6", 2'b00, 0, 1, 0, 0, 0);
    edges(1);
    chk("restart_e7", 2'b01, 1, 0, 0, 0, 0);

    // Reversal mid-travel on the DEBOUNCE=1 instance
    pulse_reset();
    sensor_f = 2'b00;
    edges(3);
    sensor_f = 2'b11;
    for (int i = 0; i < 9; i++) begin
      edges(1);
      if (i == 1) sensor_f = 2'b00;
      chk_fast($sformatf("reverse_e%0d", i + 1), f_lv[i], f_ch[i], 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
